small_comb_logic: RTL and testbench

- 8-bit combinational logic cell that packs six small Boolean/arithmetic results of one input byte into one output byte.
- Used as a leaf-level datapath helper and as a reference block for comparing HDL flavours.
- Core function is purely combinational.
- An optional output register (macro below) adds one cycle of latency; clock and reset serve only that register.

---
 rtl/small_comb_logic.sv | 58 +++++
 tb/tb_small_comb_logic.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/small_comb_logic.sv
// small_comb_logic: packs six small Boolean/arithmetic results of one input
// byte into one output byte.
//   d_out[0]   d_f   : (d0 & d1) | (~d2 & d3)
//   d_out[1]   d_inv : ~d0
//   d_out[3:2] d_xor : d[1:0] ^ d[3:2]
//   d_out[5:4] d_sum : d[5:4] + d[7:6], carry dropped
//   d_out[6]   d_and : &d
//   d_out[7]   d_or  : |d
// Optional macro SMALL_COMB_LOGIC_OUT_REG_EN adds a 1-cycle output register
// (async active-low clear). Without it the block is purely combinational and
// clk/resetn are present but have no effect.
module small_comb_logic (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] d_in,
  output logic [7:0] d_out
);

  logic       d_f;
  logic       d_inv;
  logic [1:0] d_xor;
  logic [1:0] d_sum;
  logic       d_and;
  logic       d_or;
  logic [7:0] res_d;

  // Per-field results of the input byte
  always_comb begin
    d_f   = (d_in[0] & d_in[1]) | (~d_in[2] & d_in[3]);
    d_inv = ~d_in[0];
    d_xor = d_in[1:0] ^ d_in[3:2];
    d_sum = d_in[5:4] + d_in[7:6];   // 2-bit context: carry wraps away
    d_and = &d_in;
    d_or  = |d_in;
  end

  // Fixed field layout consumers rely on
  assign res_d = {d_or, d_and, d_sum, d_xor, d_inv, d_f};

`ifdef SMALL_COMB_LOGIC_OUT_REG_EN
  logic [7:0] d_out_q;

  // Output register; reset discards any pending value immediately
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) d_out_q <= 8'h00;
    else         d_out_q <= res_d;
  end

  assign d_out = d_out_q;
`else
  // Clock and reset are kept on the port list for drop-in compatibility
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, resetn};

  assign d_out = res_d;
`endif

endmodule

// File: tb/tb_small_comb_logic.sv
// Testbench for small_comb_logic: directed literal vectors, a full 256-value
// sweep and random vectors checked every cycle against a behavioural model.
// Honours SMALL_COMB_LOGIC_OUT_REG_EN (1-cycle latency + async clear).
module tb_small_comb_logic;

  logic       clk;
  logic       resetn;
  logic [7:0] d_in;
  logic [7:0] d_out;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  small_comb_logic dut (
    .clk    (clk),
    .resetn (resetn),
    .d_in   (d_in),
    .d_out  (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: field-by-field arithmetic on the integer value
  function automatic logic [7:0] model(input int v);
    int b0, b1, b2, b3, f, inv, x, s, a, o;
    b0  = v % 2;
    b1  = (v / 2) % 2;
    b2  = (v / 4) % 2;
    b3  = (v / 8) % 2;
    f   = ((b0 == 1 && b1 == 1) || (b2 == 0 && b3 == 1)) ? 1 : 0;
    inv = 1 - b0;
    x   = ((b0 != b2) ? 1 : 0) + 2 * ((b1 != b3) ? 1 : 0);
    s   = (((v / 16) % 4) + ((v / 64) % 4)) % 4;
    a   = (v == 255) ? 1 : 0;
    o   = (v != 0) ? 1 : 0;
    model = 8'(f + 2 * inv + 4 * x + 16 * s + 64 * a + 128 * o);
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: d_in=%02h got=%02h expected=%02h", name, d_in, got, exp);
    end
  endtask

`ifdef SMALL_COMB_LOGIC_OUT_REG_EN
  // Expected registered output: value of the model at the last rising edge
  logic [7:0] exp_reg;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) exp_reg <= 8'h00;
    else         exp_reg <= model(int'(d_in));
  end
`endif

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
`ifdef SMALL_COMB_LOGIC_OUT_REG_EN
      check("model_reg", d_out, exp_reg);
`else
      check("model_comb", d_out, model(int'(d_in)));
`endif
    end
  end

  initial begin
    resetn = 1'b0;
    d_in   = 8'h00;

`ifdef SMALL_COMB_LOGIC_OUT_REG_EN
    // Reset state and registered behaviour
    d_in = 8'hFF;
    #1 check("reset_clear", d_out, 8'h00);
    repeat (2) @(posedge clk);
    #1 check("reset_hold", d_out, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    #1 check("release_no_edge", d_out, 8'h00);
    @(posedge clk);
    #1 check("first_capture", d_out, 8'hE1);
    d_in = 8'h00;
    #1 check("hold_until_edge", d_out, 8'hE1);
    @(posedge clk);
    #1 check("capture_00", d_out, 8'h02);
    d_in = 8'h24;
    @(posedge clk);
    #1 check("capture_24", d_out, 8'hA6);
    d_in = 8'h08;
    @(posedge clk);
    #1 check("capture_08", d_out, 8'h8B);
    d_in = 8'h81;
    @(posedge clk);
    #1 check("capture_81", d_out, 8'hA4);
    #2 resetn = 1'b0;
    #1 check("async_reset_midcycle", d_out, 8'h00);
    @(posedge clk);
    #1 check("reset_blocks_capture", d_out, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
`else
    // Combinational: zero latency, clk/resetn have no effect
    #1 check("reset_state_00", d_out, 8'h02);
    d_in = 8'hFF;
    #1 check("vec_FF_in_reset", d_out, 8'hE1);
    @(negedge clk);
    resetn = 1'b1;
    d_in = 8'h00;
    #1 check("vec_00", d_out, 8'h02);
    d_in = 8'hFF;
    #1 check("vec_FF", d_out, 8'hE1);
    d_in = 8'h24;
    #1 check("vec_24", d_out, 8'hA6);
    d_in = 8'h08;
    #1 check("vec_08", d_out, 8'h8B);
    d_in = 8'h81;
    #1 check("vec_81", d_out, 8'hA4);
    d_in = 8'h30;   // d_sum = 3+0
    #1 check("vec_30", d_out, 8'hB2);
    d_in = 8'hF0;   // d_sum = 3+3 wraps to 2
    #1 check("vec_F0", d_out, 8'hA2);
    d_in = 8'h03;   // d_f via d0&d1, d_xor = 11
    #1 check("vec_03", d_out, 8'h8D);
    resetn = 1'b0;
    #1 check("resetn_ignored", d_out, 8'h8D);
    resetn = 1'b1;
`endif

    // Full sweep then random vectors, one per cycle, checked at negedge
    @(posedge clk);
    #1 chk_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      d_in = 8'(i);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 10; i++) begin
      d_in = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1 chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
